// File: rtl/char_hp_ctrl_if.sv
// ----------------------------------------------------------------------------
// char_hp_ctrl_if
// Request/acknowledge bus between the damage/heal requesters and the health
// scheduler.
//   proj_req/proj_dmg : projectile hit request and its damage (held until ack)
//   heal_req/heal_amt : heal pickup request and its amount (held until ack)
//   proj_ack/heal_ack : one-cycle pulses from the scheduler, request consumed
// Modports: master = requester side, slave = char_hp_ctrl side.
// ----------------------------------------------------------------------------
interface char_hp_ctrl_if;
   localparam int unsigned VAL_W = 4;

   logic             proj_req;
   logic [VAL_W-1:0] proj_dmg;
   logic             proj_ack;
   logic             heal_req;
   logic [VAL_W-1:0] heal_amt;
   logic             heal_ack;

   modport master (
      output proj_req, proj_dmg, heal_req, heal_amt,
      input  proj_ack, heal_ack
   );

   modport slave (
      input  proj_req, proj_dmg, heal_req, heal_amt,
      output proj_ack, heal_ack
   );
endinterface

// File: rtl/char_hp_ctrl.sv
// ----------------------------------------------------------------------------
// char_hp_ctrl
// Per-frame health scheduler for the player character. Arbitrates projectile
// hits, boss body contact (bounding-box overlap) and heal pickups onto a single
// HP register, runs the post-hit invulnerability window and flags death.
//
// Ports:
//   clk, rst              : clock, synchronous active-low reset
//   frame_tick            : one-cycle pulse per frame, events evaluated here
//   game_start            : restart pulse, overrides everything else
//   game_active[1:0]      : 2'd1 = playing, any other value freezes the block
//   char_*/boss_*         : bounding boxes (top-left corner, width, height)
//   req_bus (slave)       : projectile/heal request-acknowledge bus
//   char_hp[3:0]          : current health
//   invuln, flash         : invulnerability window and its sprite blink
//   char_dead             : health reached zero
//
// Optional feature: define CHAR_HP_REGEN_EN for passive regeneration of one HP
// every REGEN_FRAMES undisturbed frames while alive.
// ----------------------------------------------------------------------------
module char_hp_ctrl #(
   parameter int unsigned HP_MAX        = 8,
   parameter int unsigned CONTACT_DMG   = 1,
   parameter int unsigned IFRAME_FRAMES = 60,
   parameter int unsigned REGEN_FRAMES  = 180
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                frame_tick,
   input  logic                game_start,
   input  logic [1:0]          game_active,
   input  logic [11:0]         char_x,
   input  logic [11:0]         char_y,
   input  logic [11:0]         char_lng,
   input  logic [11:0]         char_hgt,
   input  logic [11:0]         boss_x,
   input  logic [11:0]         boss_y,
   input  logic [11:0]         boss_lng,
   input  logic [11:0]         boss_hgt,
   char_hp_ctrl_if.slave       req_bus,
   output logic [3:0]          char_hp,
   output logic                invuln,
   output logic                flash,
   output logic                char_dead
);

   localparam int unsigned HP_W  = 4;
   localparam int unsigned CNT_W = 8;
   localparam int unsigned SUM_W = 13;

   localparam logic [HP_W-1:0] HP_FULL  = HP_W'(HP_MAX);
   localparam logic [HP_W:0]   HP_FULL5 = (HP_W+1)'(HP_MAX);
   localparam logic [HP_W-1:0] C_DMG    = HP_W'(CONTACT_DMG);
   localparam logic [CNT_W-1:0] IFR_LD  = CNT_W'(IFRAME_FRAMES);

   // Elaboration-time range checks on the configuration
   if (HP_MAX < 1 || HP_MAX > 15)                  begin : g_bad_hp    $error("HP_MAX out of range");        end
   if (CONTACT_DMG > 15)                           begin : g_bad_cdmg  $error("CONTACT_DMG out of range");   end
   if (IFRAME_FRAMES < 1 || IFRAME_FRAMES > 255)   begin : g_bad_ifr   $error("IFRAME_FRAMES out of range"); end
   if (REGEN_FRAMES < 1 || REGEN_FRAMES > 1023)    begin : g_bad_rgn   $error("REGEN_FRAMES out of range");  end

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ALIVE  = 2'd1,
      INVULN = 2'd2,
      DEAD   = 2'd3
   } state_t;

   state_t            state, state_n;
   logic [CNT_W-1:0]  ifr_cnt, ifr_cnt_n;
   logic [HP_W-1:0]   hp_n;
   logic              proj_ack_n, heal_ack_n;
   logic              invuln_n, flash_n, dead_n;
   logic              dmg_ev;
   logic              overlap;

`ifdef CHAR_HP_REGEN_EN
   localparam int unsigned RGN_W = 10;
   localparam logic [RGN_W-1:0] RGN_LIM = RGN_W'(REGEN_FRAMES);
   logic [RGN_W-1:0]  rgn_cnt, rgn_cnt_n, rgn_inc;
`endif

   // Saturating subtract: widen so the borrow is visible, clamp at 0
   function automatic logic [HP_W-1:0] sat_sub(input logic [HP_W-1:0] a,
                                                input logic [HP_W-1:0] b);
      logic [HP_W:0] a5;
      logic [HP_W:0] b5;
      a5 = {1'b0, a};
      b5 = {1'b0, b};
      return (b5 >= a5) ? '0 : HP_W'(a5 - b5);
   endfunction

   // Saturating add: widen so the carry is visible, clamp at HP_MAX
   function automatic logic [HP_W-1:0] sat_add(input logic [HP_W-1:0] a,
                                                input logic [HP_W-1:0] b);
      logic [HP_W:0] s5;
      s5 = {1'b0, a} + {1'b0, b};
      return (s5 > HP_FULL5) ? HP_FULL : HP_W'(s5);
   endfunction

   // Bounding-box overlap, strict inequalities so touching edges do not hit
   always_ff @(posedge clk) begin
      if (!rst) begin
         overlap <= 1'b0;
      end else begin
         overlap <= (SUM_W'(char_x) < SUM_W'(boss_x) + SUM_W'(boss_lng)) &&
                    (SUM_W'(boss_x) < SUM_W'(char_x) + SUM_W'(char_lng)) &&
                    (SUM_W'(char_y) < SUM_W'(boss_y) + SUM_W'(boss_hgt)) &&
                    (SUM_W'(boss_y) < SUM_W'(char_y) + SUM_W'(char_hgt));
      end
   end

   // State and output registers
   always_ff @(posedge clk) begin
      if (!rst) begin
         state            <= IDLE;
         ifr_cnt          <= '0;
         char_hp          <= HP_FULL;
         invuln           <= 1'b0;
         flash            <= 1'b0;
         char_dead        <= 1'b0;
         req_bus.proj_ack <= 1'b0;
         req_bus.heal_ack <= 1'b0;
      end else begin
         state            <= state_n;
         ifr_cnt          <= ifr_cnt_n;
         char_hp          <= hp_n;
         invuln           <= invuln_n;
         flash            <= flash_n;
         char_dead        <= dead_n;
         req_bus.proj_ack <= proj_ack_n;
         req_bus.heal_ack <= heal_ack_n;
      end
   end

`ifdef CHAR_HP_REGEN_EN
   // Passive regeneration counter
   always_ff @(posedge clk) begin
      if (!rst) begin
         rgn_cnt <= '0;
      end else begin
         rgn_cnt <= rgn_cnt_n;
      end
   end
`endif

   // Next-state, HP arbitration and output decode
   always_comb begin
      state_n    = state;
      ifr_cnt_n  = ifr_cnt;
      hp_n       = char_hp;
      proj_ack_n = 1'b0;
      heal_ack_n = 1'b0;
      dmg_ev     = 1'b0;
`ifdef CHAR_HP_REGEN_EN
      rgn_cnt_n  = rgn_cnt;
      rgn_inc    = (rgn_cnt >= RGN_LIM) ? rgn_cnt : rgn_cnt + RGN_W'(1);
`endif

      if (game_start) begin
         state_n   = ALIVE;
         hp_n      = HP_FULL;
         ifr_cnt_n = '0;
`ifdef CHAR_HP_REGEN_EN
         rgn_cnt_n = '0;
`endif
      end else if (frame_tick && (game_active == 2'd1)) begin
         unique case (state)
            IDLE: begin
            end
            ALIVE: begin
               if (req_bus.proj_req) begin
                  hp_n       = sat_sub(char_hp, req_bus.proj_dmg);
                  proj_ack_n = 1'b1;
                  dmg_ev     = 1'b1;
               end else if (overlap) begin
                  hp_n   = sat_sub(char_hp, C_DMG);
                  dmg_ev = 1'b1;
               end else if (req_bus.heal_req) begin
                  hp_n       = sat_add(char_hp, req_bus.heal_amt);
                  heal_ack_n = 1'b1;
               end
`ifdef CHAR_HP_REGEN_EN
               if (dmg_ev) begin
                  rgn_cnt_n = '0;
               end else if (!heal_ack_n && (rgn_inc == RGN_LIM) && (char_hp < HP_FULL)) begin
                  hp_n      = char_hp + HP_W'(1);
                  rgn_cnt_n = '0;
               end else begin
                  rgn_cnt_n = rgn_inc;
               end
`endif
               if (dmg_ev) begin
                  if (hp_n == '0) begin
                     state_n   = DEAD;
                     ifr_cnt_n = '0;
                  end else begin
                     state_n   = INVULN;
                     ifr_cnt_n = IFR_LD;
                  end
               end
            end
            INVULN: begin
               // Hits are swallowed, heals still land; damage check precedes decrement
               proj_ack_n = req_bus.proj_req;
               if (req_bus.heal_req) begin
                  hp_n       = sat_add(char_hp, req_bus.heal_amt);
                  heal_ack_n = 1'b1;
               end
               ifr_cnt_n = ifr_cnt - CNT_W'(1);
               if (ifr_cnt_n == '0) begin
                  state_n = ALIVE;
`ifdef CHAR_HP_REGEN_EN
                  rgn_cnt_n = '0;
`endif
               end
            end
            DEAD: begin
               proj_ack_n = req_bus.proj_req;
               heal_ack_n = req_bus.heal_req;
            end
            default: begin
               state_n = IDLE;
            end
         endcase
      end

      invuln_n = (state_n == INVULN);
      flash_n  = (state_n == INVULN) && ifr_cnt_n[2];
      dead_n   = (state_n == DEAD);
   end

endmodule

// File: doc/char_hp_ctrl.md
# char_hp_ctrl

Character health scheduler between the player/boss position outputs and the heart display. Once per frame it arbitrates three requesters for the single HP register: boss body contact (detected internally from bounding boxes), boss projectile hits and heal pickups. It also runs the post-hit invulnerability window and raises the death flag. Its `char_hp` output drives the hearts display and the game-state logic.

## Interface
- `HP_MAX`, 8: full health, 1..15.
- `CONTACT_DMG`, 1: damage per accepted contact event.
- `IFRAME_FRAMES`, 60: invulnerability length in frame ticks, 1..255.
- `REGEN_FRAMES`, 180: frames between passive regen steps, 1..1023; used only with `CHAR_HP_REGEN_EN`.

Ports:
- `clk`, in, 1: system (pixel) clock.
- `rst`, in, 1: one clock; reset is synchronous and active-low.
- `frame_tick`, in, 1: one-cycle pulse per frame (vsync start).
- `game_start`, in, 1: one-cycle pulse that restarts the round.
- `game_active`, in, 2: 2'd1 means playing; any other value freezes the block.
- `char_x`, `char_y`, `char_lng`, `char_hgt`, in, 12 each: character top-left corner, width and height.
- `boss_x`, `boss_y`, `boss_lng`, `boss_hgt`, in, 12 each: boss top-left corner, width and height.
- `proj_req`, in, 1: projectile hit request, held until acked.
- `proj_dmg`, in, 4: projectile damage, stable while `proj_req` is high.
- `heal_req`, in, 1: heal request, held until acked.
- `heal_amt`, in, 4: heal amount, stable while `heal_req` is high.
- `proj_ack`, out, 1: one-cycle pulse; request consumed.
- `heal_ack`, out, 1: one-cycle pulse; request consumed.
- `char_hp`, out, 4: current health.
- `invuln`, out, 1: invulnerability window active.
- `flash`, out, 1: blink enable for the sprite.
- `char_dead`, out, 1: health reached 0.

## Operation
- Overlap, registered every cycle: `char_x < boss_x+boss_lng` and `boss_x < char_x+char_lng`, with the same test on y. Sums are 13-bit, so there is no wrap.
- States: IDLE, ALIVE, INVULN, DEAD. After reset: IDLE, `char_hp`=HP_MAX, all other outputs 0.
- `game_start` has top priority in any state: `char_hp`=HP_MAX, i-frame counter cleared, go to ALIVE, no acks that cycle.
- IDLE leaves only on `game_start`.
- Freeze when `game_active`≠1: state, HP and counters are held and no acks are issued.
- Events are evaluated only on `frame_tick`; at most one HP change per frame.
- ALIVE arbitration, first match wins:
  - `proj_req`: HP minus `proj_dmg`.
  - Contact: HP minus CONTACT_DMG.
  - `heal_req`: HP plus `heal_amt`.
- A damage event applied in ALIVE moves to INVULN and loads the counter with IFRAME_FRAMES.
- INVULN:
  - Contact is ignored.
  - `proj_req` is acked and discarded.
  - `heal_req` is applied.
  - The counter decrements each tick; the tick that reaches 0 returns to ALIVE.
  - The damage check runs before the decrement, so the block stays invulnerable for exactly IFRAME_FRAMES ticks.
- Damage clamps at 0; heal saturates at HP_MAX. Widen to 5 bits before the add.
- HP reaching 0 goes to DEAD with `char_dead`=1. DEAD acks requests and drops them, and leaves only on `game_start`.
- A request that loses arbitration stays pending (no ack) and is retried next frame.
- `invuln` = (state==INVULN).
- `flash` = `invuln` AND counter[2], giving a 4-frame blink.

## Timing
- Overlap register: 1 cycle of latency from the position inputs.
- `char_hp`, state and acks all update on the clock edge that samples `frame_tick`; they are visible the cycle after the tick.
- Acks are a single cycle. A requester must drop or renew its request in the cycle after the ack.
  - If it is still high on the next tick, that counts as a new request.
- `game_start` in the same cycle as `frame_tick`: only the restart takes effect.
- Reset mid-INVULN: returns to IDLE and the counter clears.

## Configuration
- `CHAR_HP_REGEN_EN` defined:
  - A 10-bit regen counter runs in ALIVE on `frame_tick` and restarts on any damage event, on `game_start` and on entry to ALIVE.
  - When it reaches REGEN_FRAMES with HP<HP_MAX and no request won that tick, HP gains 1 and the counter restarts.
- `CHAR_HP_REGEN_EN` not defined: no regen counter, and REGEN_FRAMES is ignored.

## Test plan
- Restart and contact hit:
  - Stimulus: reset low 2 cycles, then `game_start`, `game_active`=1; char 100,400 size 32×48, boss 120,420 size 64×64; one tick.
  - Response: `char_hp` 8→7, `invuln`=1.
- Invulnerability window: continuous overlap, IFRAME_FRAMES=60.
  - HP stays at 7 for 60 ticks.
  - Tick 61: HP=6.
  - `flash` toggles every 4 ticks.
- Arbitration: `proj_req` with dmg 3, contact and `heal_req` with amt 2 all present in ALIVE with HP=8.
  - First tick: HP=5 and `proj_ack` pulses; heal stays pending.
  - Next tick, in INVULN: HP=7 and `heal_ack` pulses.
- Saturation:
  - HP=2 with `proj_dmg`=5: HP=0, `char_dead`=1, later requests acked with HP held at 0.
  - HP=7 with `heal_amt`=5: HP=8.
- Freeze and restart priority:
  - `game_active`=2 with requests present: no acks and HP unchanged.
  - `game_start` in the same cycle as a tick with damage pending: HP=8, ALIVE.
- Edge-touching boxes:
  - Char at x 100, width 20; boss at x 120.
  - Response: no overlap and no damage.
